fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
- Fetch-stage PC owner and IF/ID pipeline register. It sits at the receiving end of the EX-stage branch resolution interface (PcSel, BrPC).
- Holds the current PC and drives the instruction-memory address. It captures fetched instructions into IF/ID and applies load-use stalls from the hazard unit.
- On a taken branch or jump it redirects the PC, squashes the wrong-path fetch, and checks the redirect target for misalignment and range errors.

Parameters:
- PC_W, 9, width of the PC and of the instruction-memory byte address. The PC wraps modulo 2^PC_W.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) loaded into IF/ID.
- CNT_W, 16, width of the redirect performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- PcSel  in  1  EX redirect request; 1 = branch/jump taken.
- BrPC  in  32  redirect target; valid only when PcSel=1.
- Stall  in  1  hazard-unit hold; freezes PC and IF/ID.
- InstrIn  in  32  instruction-memory read data for ImemAddr, combinational same-cycle.
- ImemAddr  out  PC_W  current PC, driven directly from the PC register.
- IfId_PC  out  PC_W  PC of the instruction held in IF/ID.
- IfId_Instr  out  32  instruction held in IF/ID.
- IfId_Valid  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- Flush  out  1  combinational squash request to ID/EX; equals PcSel && state==RUN.
- MisalignErr  out  1  sticky; redirect target had BrPC[1:0]!=0.
- RangeErr  out  1  sticky; redirect target had BrPC[31:PC_W]!=0.
- RedirectCnt  out  CNT_W  count of accepted redirects, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - PC=0, IfId_PC=0, IfId_Instr=NOP_INSTR, IfId_Valid=0.
  - MisalignErr=0, RangeErr=0, RedirectCnt=0, state=BOOT.
  - Flush=0 while in reset.
- FSM states: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one cycle after rst_n deasserts.
  - PC holds at 0, IF/ID loads a bubble, and PcSel/Stall are ignored.
  - Next state is RUN.
- RUN, per rising edge, in strict priority order:
  1. PcSel=1 and BrPC[1:0]!=0:
     - MisalignErr<=1 and state<=HALT.
     - PC holds and IF/ID loads a bubble.
     - RedirectCnt does not change.
  2. PcSel=1 and aligned:
     - PC<=BrPC[PC_W-1:0] and IF/ID loads a bubble.
     - RedirectCnt increments, saturating at all-ones.
     - If BrPC[31:PC_W]!=0, RangeErr<=1 and the redirect still proceeds with the truncated target.
     - A redirect overrides Stall.
  3. Stall=1: PC and all IF/ID fields hold.
  4. Otherwise:
     - PC<=PC+4 modulo 2^PC_W.
     - IfId_PC<=PC, IfId_Instr<=InstrIn, IfId_Valid<=1.
- HALT:
  - PC holds, IF/ID loads a bubble every cycle, and PcSel/Stall are ignored.
  - Flush=0.
  - Exit only via reset.
- Latency:
  - A redirect asserted in cycle N makes ImemAddr=target in cycle N+1.
  - The first valid target instruction appears in IF/ID in cycle N+2, giving a two-cycle penalty counting the ID squash via Flush.
- Flush is purely combinational and has no registered state.
- Error flags are sticky until reset.
- Asserting rst_n mid-redirect or mid-stall discards all in-flight state immediately.

Test Plan:
- Reset release with PcSel=0, Stall=0, InstrIn=32'hA5A5_0001 -> BOOT for 1 cycle with IfId_Valid=0 and ImemAddr=0. Next edge: IfId_PC=0, IfId_Instr=32'hA5A5_0001, IfId_Valid=1, ImemAddr=4.
- Sequential fetch from PC=508 (PC_W=9) -> ImemAddr wraps to 0, and IfId_PC=508 with IfId_Valid=1.
- PcSel=1, BrPC=32'h0000_0040 while Stall=1 -> Flush=1 same cycle. Next cycle: ImemAddr=64, IfId_Valid=0, RedirectCnt=1. The redirect wins over the stall.
- Stall held 3 cycles at PC=12 with IF/ID holding PC=8 -> ImemAddr stays 12 and IF/ID is unchanged for all 3 cycles. After release, IfId_PC=12 and ImemAddr=16.
- PcSel=1, BrPC=32'h0000_0206 -> MisalignErr=1, state HALT, ImemAddr frozen, IfId_Valid=0 on all later cycles. Later PcSel pulses give Flush=0 and RedirectCnt unchanged.
- PcSel=1, BrPC=32'h0000_1010 -> RangeErr=1, ImemAddr=9'h010, fetch continues normally. Asserting rst_n=0 mid-cycle clears all outputs without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// Fetch-stage PC owner and IF/ID pipeline register.
// Takes EX branch redirects, squashes wrong-path fetches and flags bad targets.
module fetch_redirect_unit #(
   parameter int unsigned PC_W      = 9,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             PcSel,
   input  logic [31:0]      BrPC,
   input  logic             Stall,
   input  logic [31:0]      InstrIn,
   output logic [PC_W-1:0]  ImemAddr,
   output logic [PC_W-1:0]  IfId_PC,
   output logic [31:0]      IfId_Instr,
   output logic             IfId_Valid,
   output logic             Flush,
   output logic             MisalignErr,
   output logic             RangeErr,
   output logic [CNT_W-1:0] RedirectCnt
);

   // state | meaning
   // BOOT  | single cycle after reset release; PC held at 0, IF/ID bubbled
   // RUN   | normal fetch, redirect and stall handling
   // HALT  | misaligned redirect seen; PC frozen, IF/ID bubbled until reset
   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t          state;
   logic [PC_W-1:0] pc;

   assign ImemAddr = pc;
   assign Flush    = PcSel && (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BOOT;
         pc          <= '0;
         IfId_PC     <= '0;
         IfId_Instr  <= NOP_INSTR;
         IfId_Valid  <= 1'b0;
         MisalignErr <= 1'b0;
         RangeErr    <= 1'b0;
         RedirectCnt <= '0;
      end else begin
         case (state)
            BOOT: begin
               state      <= RUN;
               IfId_Instr <= NOP_INSTR;
               IfId_Valid <= 1'b0;
            end
            RUN: begin
               if (PcSel && (BrPC[1:0] != 2'b00)) begin
                  MisalignErr <= 1'b1;
                  state       <= HALT;
                  IfId_Instr  <= NOP_INSTR;
                  IfId_Valid  <= 1'b0;
               end else if (PcSel) begin
                  // out-of-range targets still redirect, using the truncated address
                  pc         <= BrPC[PC_W-1:0];
                  IfId_Instr <= NOP_INSTR;
                  IfId_Valid <= 1'b0;
                  if (RedirectCnt != '1)
                     RedirectCnt <= RedirectCnt + CNT_W'(1);
                  if (|BrPC[31:PC_W])
                     RangeErr <= 1'b1;
               end else if (!Stall) begin
                  pc         <= pc + PC_W'(4);
                  IfId_PC    <= pc;
                  IfId_Instr <= InstrIn;
                  IfId_Valid <= 1'b1;
               end
            end
            HALT: begin
               IfId_Instr <= NOP_INSTR;
               IfId_Valid <= 1'b0;
            end
            default: begin
               state      <= HALT;
               IfId_Instr <= NOP_INSTR;
               IfId_Valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: reset/boot, wrap, redirect vs stall,
// stall hold, range and misalign errors, asynchronous reset.
module tb_fetch_redirect_unit;

   localparam int unsigned PC_W  = 9;
   localparam int unsigned CNT_W = 16;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic             clk;
   logic             rst_n;
   logic             PcSel;
   logic [31:0]      BrPC;
   logic             Stall;
   logic [31:0]      InstrIn;
   logic [PC_W-1:0]  ImemAddr;
   logic [PC_W-1:0]  IfId_PC;
   logic [31:0]      IfId_Instr;
   logic             IfId_Valid;
   logic             Flush;
   logic             MisalignErr;
   logic             RangeErr;
   logic [CNT_W-1:0] RedirectCnt;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_redirect_unit #(.PC_W(PC_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .PcSel(PcSel), .BrPC(BrPC), .Stall(Stall),
      .InstrIn(InstrIn), .ImemAddr(ImemAddr), .IfId_PC(IfId_PC),
      .IfId_Instr(IfId_Instr), .IfId_Valid(IfId_Valid), .Flush(Flush),
      .MisalignErr(MisalignErr), .RangeErr(RangeErr), .RedirectCnt(RedirectCnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; PcSel = 1'b0; Stall = 1'b0; BrPC = '0;
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; PcSel = 1'b1; BrPC = 32'h40; Stall = 1'b0; InstrIn = 32'hA5A5_0001;
      step(); step();
      n_checks++; if (Flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b exp 0", Flush); end
      n_checks++; if (ImemAddr !== 9'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", ImemAddr); end
      n_checks++; if (IfId_Instr !== NOP) begin n_fail++; $display("FAIL reset_instr got %h exp %h", IfId_Instr, NOP); end
      n_checks++; if (IfId_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", IfId_Valid); end
      n_checks++; if ({MisalignErr, RangeErr} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got %b exp 00", {MisalignErr, RangeErr}); end
      n_checks++; if (RedirectCnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", RedirectCnt); end
      // BOOT ignores a redirect request
      rst_n = 1'b1;
      #1;
      n_checks++; if (Flush !== 1'b0) begin n_fail++; $display("FAIL boot_flush got %b exp 0", Flush); end
      step();
      n_checks++; if (ImemAddr !== 9'd0) begin n_fail++; $display("FAIL boot_addr got %0d exp 0", ImemAddr); end
      n_checks++; if (IfId_Valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b exp 0", IfId_Valid); end
      n_checks++; if (RedirectCnt !== 16'd0) begin n_fail++; $display("FAIL boot_cnt got %0d exp 0", RedirectCnt); end
      PcSel = 1'b0;
      step();
      n_checks++; if (IfId_PC !== 9'd0) begin n_fail++; $display("FAIL first_pc got %0d exp 0", IfId_PC); end
      n_checks++; if (IfId_Instr !== 32'hA5A5_0001) begin n_fail++; $display("FAIL first_instr got %h exp a5a50001", IfId_Instr); end
      n_checks++; if (IfId_Valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b exp 1", IfId_Valid); end
      n_checks++; if (ImemAddr !== 9'd4) begin n_fail++; $display("FAIL first_addr got %0d exp 4", ImemAddr); end
   endtask

   task automatic test_wrap();
      PcSel = 1'b1; BrPC = 32'h0000_01FC;
      #1;
      n_checks++; if (Flush !== 1'b1) begin n_fail++; $display("FAIL wrap_flush got %b exp 1", Flush); end
      step();
      n_checks++; if (ImemAddr !== 9'd508) begin n_fail++; $display("FAIL wrap_target got %0d exp 508", ImemAddr); end
      n_checks++; if (IfId_Valid !== 1'b0) begin n_fail++; $display("FAIL wrap_squash got %b exp 0", IfId_Valid); end
      n_checks++; if (RedirectCnt !== 16'd1) begin n_fail++; $display("FAIL wrap_cnt got %0d exp 1", RedirectCnt); end
      PcSel = 1'b0; InstrIn = 32'hDEAD_0001;
      step();
      n_checks++; if (ImemAddr !== 9'd0) begin n_fail++; $display("FAIL wrap_addr got %0d exp 0", ImemAddr); end
      n_checks++; if (IfId_PC !== 9'd508) begin n_fail++; $display("FAIL wrap_ifid_pc got %0d exp 508", IfId_PC); end
      n_checks++; if (IfId_Valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got %b exp 1", IfId_Valid); end
      n_checks++; if (IfId_Instr !== 32'hDEAD_0001) begin n_fail++; $display("FAIL wrap_instr got %h exp dead0001", IfId_Instr); end
   endtask

   task automatic test_redirect_over_stall();
      PcSel = 1'b1; BrPC = 32'h0000_0040; Stall = 1'b1;
      #1;
      n_checks++; if (Flush !== 1'b1) begin n_fail++; $display("FAIL rs_flush got %b exp 1", Flush); end
      step();
      n_checks++; if (ImemAddr !== 9'd64) begin n_fail++; $display("FAIL rs_addr got %0d exp 64", ImemAddr); end
      n_checks++; if (IfId_Valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid got %b exp 0", IfId_Valid); end
      n_checks++; if (RedirectCnt !== 16'd2) begin n_fail++; $display("FAIL rs_cnt got %0d exp 2", RedirectCnt); end
      PcSel = 1'b0; Stall = 1'b0;
   endtask

   task automatic test_stall();
      PcSel = 1'b1; BrPC = 32'h0000_0008;
      step();
      PcSel = 1'b0; InstrIn = 32'h1111_0008;
      step();
      n_checks++; if (ImemAddr !== 9'd12 || IfId_PC !== 9'd8) begin n_fail++; $display("FAIL stall_setup got addr %0d pc %0d exp 12 8", ImemAddr, IfId_PC); end
      Stall = 1'b1; InstrIn = 32'h2222_000C;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (ImemAddr !== 9'd12) begin n_fail++; $display("FAIL stall_addr[%0d] got %0d exp 12", i, ImemAddr); end
         n_checks++; if (IfId_PC !== 9'd8 || IfId_Instr !== 32'h1111_0008 || IfId_Valid !== 1'b1)
            begin n_fail++; $display("FAIL stall_ifid[%0d] got %0d %h %b exp 8 11110008 1", i, IfId_PC, IfId_Instr, IfId_Valid); end
      end
      Stall = 1'b0;
      step();
      n_checks++; if (IfId_PC !== 9'd12 || IfId_Instr !== 32'h2222_000C) begin n_fail++; $display("FAIL stall_release got %0d %h exp 12 2222000c", IfId_PC, IfId_Instr); end
      n_checks++; if (ImemAddr !== 9'd16) begin n_fail++; $display("FAIL stall_release_addr got %0d exp 16", ImemAddr); end
   endtask

   task automatic test_range();
      PcSel = 1'b1; BrPC = 32'h0000_1010;
      step();
      n_checks++; if (RangeErr !== 1'b1) begin n_fail++; $display("FAIL range_flag got %b exp 1", RangeErr); end
      n_checks++; if (ImemAddr !== 9'h010) begin n_fail++; $display("FAIL range_addr got %h exp 010", ImemAddr); end
      n_checks++; if (MisalignErr !== 1'b0) begin n_fail++; $display("FAIL range_misalign got %b exp 0", MisalignErr); end
      n_checks++; if (RedirectCnt !== 16'd4) begin n_fail++; $display("FAIL range_cnt got %0d exp 4", RedirectCnt); end
      PcSel = 1'b0; InstrIn = 32'h3333_0010;
      step();
      n_checks++; if (IfId_PC !== 9'h010 || IfId_Valid !== 1'b1 || ImemAddr !== 9'h014)
         begin n_fail++; $display("FAIL range_fetch got pc %h v %b addr %h exp 010 1 014", IfId_PC, IfId_Valid, ImemAddr); end
      n_checks++; if (RangeErr !== 1'b1) begin n_fail++; $display("FAIL range_sticky got %b exp 1", RangeErr); end
   endtask

   task automatic test_misalign();
      PcSel = 1'b1; BrPC = 32'h0000_0206;
      #1;
      n_checks++; if (Flush !== 1'b1) begin n_fail++; $display("FAIL mis_flush got %b exp 1", Flush); end
      step();
      n_checks++; if (MisalignErr !== 1'b1) begin n_fail++; $display("FAIL mis_flag got %b exp 1", MisalignErr); end
      n_checks++; if (ImemAddr !== 9'h014) begin n_fail++; $display("FAIL mis_addr got %h exp 014", ImemAddr); end
      n_checks++; if (IfId_Valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid got %b exp 0", IfId_Valid); end
      n_checks++; if (RedirectCnt !== 16'd4) begin n_fail++; $display("FAIL mis_cnt got %0d exp 4", RedirectCnt); end
      BrPC = 32'h0000_0040;
      #1;
      n_checks++; if (Flush !== 1'b0) begin n_fail++; $display("FAIL halt_flush got %b exp 0", Flush); end
      step();
      n_checks++; if (ImemAddr !== 9'h014 || RedirectCnt !== 16'd4) begin n_fail++; $display("FAIL halt_redirect got addr %h cnt %0d exp 014 4", ImemAddr, RedirectCnt); end
      PcSel = 1'b0;
      step(); step();
      n_checks++; if (ImemAddr !== 9'h014 || IfId_Valid !== 1'b0) begin n_fail++; $display("FAIL halt_frozen got addr %h v %b exp 014 0", ImemAddr, IfId_Valid); end
      n_checks++; if (MisalignErr !== 1'b1) begin n_fail++; $display("FAIL mis_sticky got %b exp 1", MisalignErr); end
   endtask

   task automatic test_async_reset();
      do_reset();
      step();
      PcSel = 1'b1; BrPC = 32'h0000_1010;
      step();
      n_checks++; if (RangeErr !== 1'b1 || RedirectCnt !== 16'd1) begin n_fail++; $display("FAIL ar_setup got r %b cnt %0d exp 1 1", RangeErr, RedirectCnt); end
      BrPC = 32'h0000_0080;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (ImemAddr !== 9'd0 || IfId_PC !== 9'd0) begin n_fail++; $display("FAIL ar_pc got %0d %0d exp 0 0", ImemAddr, IfId_PC); end
      n_checks++; if (IfId_Instr !== NOP || IfId_Valid !== 1'b0) begin n_fail++; $display("FAIL ar_ifid got %h %b exp %h 0", IfId_Instr, IfId_Valid, NOP); end
      n_checks++; if (RangeErr !== 1'b0 || MisalignErr !== 1'b0 || RedirectCnt !== 16'd0)
         begin n_fail++; $display("FAIL ar_status got r %b m %b cnt %0d exp 0 0 0", RangeErr, MisalignErr, RedirectCnt); end
      n_checks++; if (Flush !== 1'b0) begin n_fail++; $display("FAIL ar_flush got %b exp 0", Flush); end
      step();
      PcSel = 1'b0;
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n = 1'b0; PcSel = 1'b0; Stall = 1'b0; BrPC = '0; InstrIn = '0;
      step();
      test_reset();
      test_wrap();
      test_redirect_over_stall();
      test_stall();
      test_range();
      test_misalign();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
